// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC ownership, SRAM request, IF-to-ID handshake, branch redirect
//
// Optional feature macro: IF_INST_BUF_EN
//   defined   : a one-entry instruction buffer holds the fetched word while
//               decode stalls, so the SRAM may change rdata while en=0.
//   undefined : if_to_id_bus[31:0] comes straight from inst_sram_rdata; the
//               SRAM is relied upon to hold rdata while en=0.
//
// Ports:
//   clk, rst         pipeline clock; asynchronous active-high reset
//   id_allowin       decode can accept an instruction this cycle
//   br_bus           {br_taken, br_target[31:0]} from decode
//   if_validout      if_to_id_bus carries a live instruction
//   if_to_id_bus     {pc[31:0], inst[31:0]}
//   inst_sram_*      synchronous instruction SRAM request/response (read-only)
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allowin,
    input  logic [32:0] br_bus,
    output logic        if_validout,
    output logic [63:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        started;
    logic        fs_valid;
    logic [31:0] fs_pc;

    logic        br_taken;
    logic [31:0] br_target;
    logic        to_fs_valid;
    logic        fs_readygo;
    logic        fs_allowin;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // Pre-IF: the request for nextpc goes out in the same cycle IF can take it.
    assign to_fs_valid = started;
    assign nextpc      = br_taken ? br_target : fs_pc + 32'd4;

    assign fs_readygo  = 1'b1;
    assign fs_allowin  = ~fs_valid | (fs_readygo & id_allowin);

    // A taken branch means the word in IF is the branch's fall-through successor.
    assign if_validout = fs_valid & fs_readygo & ~br_taken;

    assign inst_sram_en    = to_fs_valid & fs_allowin;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'b0;

    assign if_to_id_bus = {fs_pc, fs_inst};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started  <= 1'b0;
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else begin
            started <= 1'b1;
            if (to_fs_valid & fs_allowin) begin
                fs_valid <= 1'b1;
                fs_pc    <= nextpc;
            end
        end
    end

`ifdef IF_INST_BUF_EN
    logic [31:0] inst_buf;
    logic        buf_valid;
    logic        buf_capture;
    logic        buf_clear;

    // Capture on the first stalled edge, while rdata is still the word fetched
    // for fs_pc; clearing wins over capture.
    assign buf_capture = fs_valid & ~id_allowin & ~buf_valid;
    assign buf_clear   = (if_validout & id_allowin) | (br_taken & fs_allowin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_buf  <= 32'b0;
            buf_valid <= 1'b0;
        end else if (buf_clear) begin
            buf_valid <= 1'b0;
        end else if (buf_capture) begin
            inst_buf  <= inst_sram_rdata;
            buf_valid <= 1'b1;
        end
    end

    assign fs_inst = buf_valid ? inst_buf : inst_sram_rdata;
`else
    assign fs_inst = inst_sram_rdata;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage: cycle vectors plus accepted-instruction scoreboard
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_allowin = 1'b0;
    logic [32:0] br_bus = 33'b0;
    logic        if_validout;
    logic [63:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] sb[$];

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .id_allowin     (id_allowin),
        .br_bus         (br_bus),
        .if_validout    (if_validout),
        .if_to_id_bus   (if_to_id_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM returns its address as data; with the buffer compiled in, rdata is
    // corrupted whenever no request is made, to prove the buffer holds the word.
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= inst_sram_addr;
`ifdef IF_INST_BUF_EN
        else
            inst_sram_rdata <= 32'hdeadbeef;
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every instruction decode accepts must match the next expected pc,
    // with inst equal to pc because the SRAM echoes its address.
    always @(negedge clk) begin
        if (if_validout === 1'b1 && id_allowin === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%h required=none", if_to_id_bus[63:32]);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("sb_pc", if_to_id_bus[63:32], e);
                chk("sb_inst", if_to_id_bus[31:0], e);
            end
        end
    end

    typedef struct {
        logic        allow;
        logic        br;
        logic [31:0] tgt;
        logic        ev;
        logic        een;
        logic [31:0] eaddr;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic allow, logic br, logic [31:0] tgt,
                                logic ev, logic een, logic [31:0] eaddr, logic [31:0] epc);
        vec_t v;
        v.allow = allow; v.br = br; v.tgt = tgt;
        v.ev = ev; v.een = een; v.eaddr = eaddr; v.epc = epc;
        return v;
    endfunction

    initial begin
        #20000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        //             allow br  target        valid en  addr          pc
        vecs[0]  = mk(1, 0, 32'h0,        0, 1, 32'h1c000000, 32'h1bfffffc); // first request
        vecs[1]  = mk(1, 0, 32'h0,        1, 1, 32'h1c000004, 32'h1c000000);
        vecs[2]  = mk(1, 0, 32'h0,        1, 1, 32'h1c000008, 32'h1c000004);
        vecs[3]  = mk(0, 0, 32'h0,        1, 0, 32'h1c00000c, 32'h1c000008); // stall x3
        vecs[4]  = mk(0, 0, 32'h0,        1, 0, 32'h1c00000c, 32'h1c000008);
        vecs[5]  = mk(0, 0, 32'h0,        1, 0, 32'h1c00000c, 32'h1c000008);
        vecs[6]  = mk(1, 0, 32'h0,        1, 1, 32'h1c00000c, 32'h1c000008);
        vecs[7]  = mk(1, 1, 32'h1c000100, 0, 1, 32'h1c000100, 32'h1c00000c); // taken branch
        vecs[8]  = mk(1, 0, 32'h0,        1, 1, 32'h1c000104, 32'h1c000100);
        vecs[9]  = mk(0, 1, 32'h1c000200, 0, 0, 32'h1c000200, 32'h1c000104); // branch in stall
        vecs[10] = mk(0, 1, 32'h1c000200, 0, 0, 32'h1c000200, 32'h1c000104);
        vecs[11] = mk(1, 1, 32'h1c000200, 0, 1, 32'h1c000200, 32'h1c000104);
        vecs[12] = mk(1, 0, 32'h0,        1, 1, 32'h1c000204, 32'h1c000200);
        vecs[13] = mk(1, 1, 32'hfffffffc, 0, 1, 32'hfffffffc, 32'h1c000204); // to wrap point
        vecs[14] = mk(1, 0, 32'h0,        1, 1, 32'h00000000, 32'hfffffffc);
        vecs[15] = mk(1, 0, 32'h0,        1, 1, 32'h00000004, 32'h00000000);

        sb.push_back(32'h1c000000);
        sb.push_back(32'h1c000004);
        sb.push_back(32'h1c000008);
        sb.push_back(32'h1c000100);
        sb.push_back(32'h1c000200);
        sb.push_back(32'hfffffffc);
        sb.push_back(32'h00000000);

        // Reset asserted and released away from clock edges.
        #2 rst = 1'b1;
        id_allowin = 1'b1;
        #10;
        chk("rst_validout", {31'b0, if_validout}, 32'd0);
        chk("rst_en", {31'b0, inst_sram_en}, 32'd0);
        chk("rst_pc", if_to_id_bus[63:32], RESET_PC - 32'd4);
        #1 rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            id_allowin = vecs[i].allow;
            br_bus     = {vecs[i].br, vecs[i].tgt};
            @(negedge clk);
            chk($sformatf("v%0d_validout", i), {31'b0, if_validout}, {31'b0, vecs[i].ev});
            chk($sformatf("v%0d_en", i), {31'b0, inst_sram_en}, {31'b0, vecs[i].een});
            chk($sformatf("v%0d_addr", i), inst_sram_addr, vecs[i].eaddr);
            chk($sformatf("v%0d_pc", i), if_to_id_bus[63:32], vecs[i].epc);
            if (vecs[i].ev)
                chk($sformatf("v%0d_inst", i), if_to_id_bus[31:0], vecs[i].epc);
            chk($sformatf("v%0d_no_x", i),
                {31'b0, $isunknown({if_validout, if_to_id_bus, inst_sram_en, inst_sram_addr})}, 32'd0);
            chk($sformatf("v%0d_tied", i), {inst_sram_we, inst_sram_wdata[27:0]}, 32'd0);
        end

        // Reset mid-operation: takes effect without a clock edge, then refetch from RESET_PC.
        #2 rst = 1'b1;
        #1;
        chk("midrst_validout", {31'b0, if_validout}, 32'd0);
        chk("midrst_en", {31'b0, inst_sram_en}, 32'd0);
        chk("midrst_pc", if_to_id_bus[63:32], RESET_PC - 32'd4);
        id_allowin = 1'b1;
        br_bus     = 33'b0;
        sb.push_back(RESET_PC);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("refetch_validout0", {31'b0, if_validout}, 32'd0);
        chk("refetch_en", {31'b0, inst_sram_en}, 32'd1);
        chk("refetch_addr", inst_sram_addr, RESET_PC);
        @(posedge clk);
        @(negedge clk);
        chk("refetch_validout1", {31'b0, if_validout}, 32'd1);
        chk("refetch_pc", if_to_id_bus[63:32], RESET_PC);
        chk("refetch_inst", if_to_id_bus[31:0], RESET_PC);
        @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage LoongArch-subset pipeline, sitting directly upstream of the decode stage. It owns the PC and issues next-PC requests to the synchronous instruction SRAM. It delivers {pc, inst} to decode through the valid/allowin handshake, and redirects on the branch bus that decode drives back.

## Interface
- RESET_PC, 32'h1c00_0000, address of the first instruction fetched after reset.
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- id_allowin  input  1  decode can accept an instruction this cycle.
- br_bus  input  33  {br_taken[32], br_target[31:0]}.
  - br_taken is already qualified by decode's valid.
- if_validout  output  1  if_to_id_bus holds a live instruction.
- if_to_id_bus  output  64  {pc[63:32], inst[31:0]}.
- inst_sram_en  output  1  SRAM read enable.
- inst_sram_we  output  4  byte write enables, tied 4'b0.
- inst_sram_addr  output  32  fetch address (nextpc).
- inst_sram_wdata  output  32  tied 32'b0.
- inst_sram_rdata  input  32  read data, valid one cycle after an enabled request.

## Operation
- **State.**
  - started: 1 bit.
  - fs_valid: 1 bit.
  - fs_pc: 32 bits.
  - inst_buf: 32 bits, present only when IF_INST_BUF_EN is defined.
  - buf_valid: 1 bit, present only when IF_INST_BUF_EN is defined.
- **Reset values.**
  - started=0, fs_valid=0, fs_pc=RESET_PC-4, buf_valid=0, inst_buf=0.
  - While in reset: if_validout=0, inst_sram_en=0.
- **Pre-IF.**
  - to_fs_valid = started.
  - nextpc = br_taken ? br_target : fs_pc+4, 32-bit wrap-around and no trap on overflow.
  - inst_sram_addr = nextpc.
  - inst_sram_en = to_fs_valid & fs_allowin.
- **Handshake.**
  - fs_readygo=1.
  - fs_allowin = ~fs_valid | (fs_readygo & id_allowin).
  - if_validout = fs_valid & fs_readygo & ~br_taken.
- **Advance.** When to_fs_valid & fs_allowin: fs_valid<=1 and fs_pc<=nextpc.
- **Branch cancel.** When br_taken=1, the instruction currently in IF is the sequential successor of the branch and is discarded.
  - It is masked from if_validout.
  - It is overwritten when IF next advances, at which point fs_pc becomes br_target exactly once.
- **Branch while decode is stalled.** br_taken is held while decode is stalled (id_allowin=0).
  - IF holds and keeps if_validout=0.
  - The redirect takes effect on the edge where id_allowin=1.
- **Output select.** if_to_id_bus[31:0] = buf_valid ? inst_buf : inst_sram_rdata.
- **Instruction buffer, when compiled in.**
  - Capture: if fs_valid & ~id_allowin & ~buf_valid, then inst_buf<=inst_sram_rdata and buf_valid<=1.
  - Clear buf_valid on (if_validout & id_allowin), or on br_taken & fs_allowin.
  - Capture and clear in the same cycle resolve to clear.
- **Reset mid-operation.** All state returns to reset values immediately, regardless of clock. Any SRAM data arriving afterwards is ignored.

## Timing
- Reset release: edge 1 sets started.
  - During the following cycle, inst_sram_en=1 with addr=RESET_PC.
  - Edge 2 sets fs_valid=1 and fs_pc=RESET_PC, so if_validout=1 one cycle later.
- Steady state, id_allowin=1 continuously:
  - one instruction per cycle;
  - pc increments by 4 each cycle;
  - SRAM-to-decode latency of 1 cycle (request in pre-IF, data in IF).
- Taken branch costs 1 bubble: if_validout=0 in the cycle br_taken=1. The target instruction is valid 1 cycle later.
- Stall: when id_allowin=0 with fs_valid=1:
  - inst_sram_en=0;
  - fs_pc and if_to_id_bus are held stable;
  - no request is issued.
- if_to_id_bus is only meaningful when if_validout=1.

## Configuration
- IF_INST_BUF_EN defined:
  - inst_buf/buf_valid are implemented;
  - the held instruction is correct even if the SRAM changes rdata while en=0.
- Not defined:
  - no buffer; if_to_id_bus[31:0] = inst_sram_rdata;
  - correctness relies on the SRAM holding rdata while en=0, which the block RAM used in this design does.

## Test plan
- **Reset and first fetch.** Assert rst mid-cycle, release.
  - inst_sram_addr=0x1c000000 with en=1 one cycle after release.
  - Then if_validout=1, pc=0x1c000000.
- **Sequential stream.** id_allowin=1, SRAM returns addr as data.
  - pc sequence 0x1c000000, 0x1c000004, 0x1c000008; inst equal to pc each cycle.
- **Stall.** id_allowin=0 for 3 cycles at pc=0x1c000008.
  - en=0 and outputs held for all 3 cycles.
  - With IF_INST_BUF_EN defined and SRAM rdata corrupted to 0xdeadbeef during the stall, inst still equals the original word.
- **Taken branch.** br_bus={1, 0x1c000100} for 1 cycle while IF holds 0x1c00000c.
  - if_validout=0 that cycle.
  - Next cycle pc=0x1c000100; 0x1c00000c is never accepted by decode.
- **Branch during decode stall.** br_taken=1 with id_allowin=0 for 2 cycles, then id_allowin=1.
  - Single redirect: pc=br_target after that edge; no duplicate or skipped fetch.
- **Wrap-around.** Force fs_pc=0xfffffffc.
  - nextpc=0x00000000, no X on any output.
